// File: rtl/video_capture_if.sv
// Video capture bus: raw video input, framebuffer write port and the
// frame-done / frame-flipped handshake with the double-buffer logic.
interface video_capture_if;
    logic        aHorizontalSync;
    logic        aVerticalSync;
    logic        aDisplayEnabled;
    logic [7:0]  aRed;
    logic [7:0]  aGreen;
    logic [7:0]  aBlue;
    logic        aFrameFlipped;
    logic [17:0] anOutWriteAddress;
    logic [2:0]  anOutWriteData;
    logic        anOutWriteEnable;
    logic        anOutFrameDone;
    logic        anOutShortFrame;
    logic [7:0]  anOutDroppedFrames;

    // Capture side: consumes video, drives the framebuffer write port.
    modport master (
        input  aHorizontalSync, aVerticalSync, aDisplayEnabled,
        input  aRed, aGreen, aBlue, aFrameFlipped,
        output anOutWriteAddress, anOutWriteData, anOutWriteEnable,
        output anOutFrameDone, anOutShortFrame, anOutDroppedFrames
    );

    // Top-level side: supplies video and flip pulses, observes writes.
    modport slave (
        output aHorizontalSync, aVerticalSync, aDisplayEnabled,
        output aRed, aGreen, aBlue, aFrameFlipped,
        input  anOutWriteAddress, anOutWriteData, anOutWriteEnable,
        input  anOutFrameDone, anOutShortFrame, anOutDroppedFrames
    );
endinterface

// File: rtl/video_capture.sv
// Video capture: downscales an RGB888 stream 2:1 in X and Y into 3-bit
// framebuffer pixels and hands finished frames to the double-buffer logic.
module video_capture #(
    parameter int SRC_WIDTH       = 640,
    parameter int SRC_HEIGHT      = 480,
    parameter int DST_WIDTH       = 320,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input logic             aClock,
    input logic             aReset,
    video_capture_if.master aBus
);
    localparam logic [1:0]  IDLE      = 2'd0;
    localparam logic [1:0]  ARMED     = 2'd1;
    localparam logic [1:0]  CAPTURE   = 2'd2;
    localparam logic [1:0]  DONE      = 2'd3;
    localparam logic [9:0]  SRC_W     = 10'(SRC_WIDTH);
    localparam logic [8:0]  SRC_H     = 9'(SRC_HEIGHT);
    localparam logic [8:0]  LAST_LINE = 9'(SRC_HEIGHT - 1);
    localparam logic [17:0] ROW_STEP  = 18'(DST_WIDTH);
    localparam logic        SYNC_INV  = (SYNC_ACTIVE_LOW != 0);

    logic [1:0]  state;
    logic        vSync_p0, vSync_p1;
    logic        de_p0, de_p1;
    logic        flip_p0;
    logic [2:0]  pixMsb_p0;
    logic [9:0]  srcX;
    logic [8:0]  srcY;
    logic [17:0] rowBase;
    logic        vsyncStart, lineEnd, lastLineEnd, sampleHit;
    logic        writeEnable_p1;
    logic [17:0] writeAddress_p1;
    logic [2:0]  writeData_p1;
    logic        shortFrame;
    logic [7:0]  droppedFrames;
    logic        unusedInputs;

    // Horizontal sync and the colour LSBs carry nothing the 3-bit format needs.
    assign unusedInputs = ^{aBus.aHorizontalSync, aBus.aRed[6:0],
                            aBus.aGreen[6:0], aBus.aBlue[6:0]};

    // ---- stage p0: input register, syncs normalised to active-high ----
    // Register control inputs; keep one extra delay for edge detection.
    always_ff @(posedge aClock or negedge aReset) begin
        if (!aReset) begin
            vSync_p0 <= 1'b0;
            vSync_p1 <= 1'b0;
            de_p0    <= 1'b0;
            de_p1    <= 1'b0;
            flip_p0  <= 1'b0;
        end else begin
            vSync_p0 <= aBus.aVerticalSync ^ SYNC_INV;
            vSync_p1 <= vSync_p0;
            de_p0    <= aBus.aDisplayEnabled;
            de_p1    <= de_p0;
            flip_p0  <= aBus.aFrameFlipped;
        end
    end

    // Register the colour MSBs that form the framebuffer pixel.
    always_ff @(posedge aClock) begin
        pixMsb_p0 <= {aBus.aRed[7], aBus.aGreen[7], aBus.aBlue[7]};
    end

    assign vsyncStart  = vSync_p0 & ~vSync_p1;
    assign lineEnd     = de_p1 & ~de_p0;
    assign lastLineEnd = lineEnd && (srcY == LAST_LINE);
    assign sampleHit   = (state == CAPTURE) && de_p0 && !srcX[0] && !srcY[0] &&
                         (srcX < SRC_W) && (srcY < SRC_H);

    // Track source position; counters saturate so oversized input cannot wrap
    // back into the active window.
    always_ff @(posedge aClock or negedge aReset) begin
        if (!aReset) begin
            srcX    <= '0;
            srcY    <= '0;
            rowBase <= '0;
        end else begin
            if (lineEnd)
                srcX <= '0;
            else if (de_p0 && srcX != '1)
                srcX <= srcX + 10'd1;

            if (vsyncStart) begin
                srcY    <= '0;
                rowBase <= '0;
            end else if (lineEnd) begin
                if (srcY != '1)
                    srcY <= srcY + 9'd1;
                if (srcY[0] && srcY < SRC_H)
                    rowBase <= rowBase + ROW_STEP;
            end
        end
    end

    // Frame sequencing: arm on a frame boundary, capture, wait for the flip.
    always_ff @(posedge aClock or negedge aReset) begin
        if (!aReset) begin
            state         <= IDLE;
            shortFrame    <= 1'b0;
            droppedFrames <= '0;
        end else begin
            shortFrame <= 1'b0;
            case (state)
                IDLE:    if (vsyncStart) state <= ARMED;
                ARMED:   if (vsyncStart) state <= CAPTURE;
                CAPTURE: begin
                    if (lastLineEnd) begin
                        state <= DONE;
                    end else if (vsyncStart) begin
                        state <= ARMED;
                        if (srcY < LAST_LINE)
                            shortFrame <= 1'b1;
                    end
                end
                DONE: begin
                    // A flip coinciding with vsync is not a frame start.
                    if (flip_p0)
                        state <= ARMED;
                    else if (vsyncStart && droppedFrames != 8'hFF)
                        droppedFrames <= droppedFrames + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---- stage p1: framebuffer write port ----
    // Issue one write per kept pixel, one cycle after the input register.
    always_ff @(posedge aClock or negedge aReset) begin
        if (!aReset) begin
            writeEnable_p1  <= 1'b0;
            writeAddress_p1 <= '0;
            writeData_p1    <= '0;
        end else begin
            writeEnable_p1 <= sampleHit;
            if (sampleHit) begin
                writeAddress_p1 <= rowBase + {9'd0, srcX[9:1]};
                writeData_p1    <= pixMsb_p0;
            end
        end
    end

    assign aBus.anOutWriteEnable   = writeEnable_p1;
    assign aBus.anOutWriteAddress  = writeAddress_p1;
    assign aBus.anOutWriteData     = writeData_p1;
    assign aBus.anOutFrameDone     = (state == DONE);
    assign aBus.anOutShortFrame    = shortFrame;
    assign aBus.anOutDroppedFrames = droppedFrames;
endmodule

// File: tb/tb_video_capture.sv
// Bench for video_capture on a reduced 16x12 -> 8x6 geometry. Two instances
// run side by side: active-low syncs and active-high (inverted) syncs.
module tb_video_capture;
    localparam int W    = 16;
    localparam int H    = 12;
    localparam int DW   = 8;
    localparam int NPIX = 48;

    logic aClock = 1'b0;
    always #5 aClock = ~aClock;

    logic       aReset;
    logic       vs, hs, de, flip;
    logic [7:0] r, g, b;
    int         tests = 0;
    int         fails = 0;

    video_capture_if bus0 ();
    video_capture_if bus1 ();

    assign bus0.aVerticalSync   = ~vs;
    assign bus0.aHorizontalSync = ~hs;
    assign bus1.aVerticalSync   = vs;
    assign bus1.aHorizontalSync = hs;
    assign bus0.aDisplayEnabled = de;
    assign bus1.aDisplayEnabled = de;
    assign bus0.aRed = r;   assign bus1.aRed = r;
    assign bus0.aGreen = g; assign bus1.aGreen = g;
    assign bus0.aBlue = b;  assign bus1.aBlue = b;
    assign bus0.aFrameFlipped = flip;
    assign bus1.aFrameFlipped = flip;

    video_capture #(.SRC_WIDTH(W), .SRC_HEIGHT(H), .DST_WIDTH(DW), .SYNC_ACTIVE_LOW(1))
        dut0 (.aClock(aClock), .aReset(aReset), .aBus(bus0));
    video_capture #(.SRC_WIDTH(W), .SRC_HEIGHT(H), .DST_WIDTH(DW), .SYNC_ACTIVE_LOW(0))
        dut1 (.aClock(aClock), .aReset(aReset), .aBus(bus1));

    logic        weO [2];
    logic        doneO [2];
    logic        shortO [2];
    logic [7:0]  dropO [2];
    logic [17:0] addrO [2];
    logic [2:0]  dataO [2];
    assign weO[0] = bus0.anOutWriteEnable;    assign weO[1] = bus1.anOutWriteEnable;
    assign doneO[0] = bus0.anOutFrameDone;    assign doneO[1] = bus1.anOutFrameDone;
    assign shortO[0] = bus0.anOutShortFrame;  assign shortO[1] = bus1.anOutShortFrame;
    assign dropO[0] = bus0.anOutDroppedFrames; assign dropO[1] = bus1.anOutDroppedFrames;
    assign addrO[0] = bus0.anOutWriteAddress; assign addrO[1] = bus1.anOutWriteAddress;
    assign dataO[0] = bus0.anOutWriteData;    assign dataO[1] = bus1.anOutWriteData;

    // Write monitor: counts, ordering, spacing and captured pixel data.
    int         wrCount [2];
    int         orderErr [2];
    int         shortCount [2];
    int         nextAddr [2];
    int         maxAddr [2];
    logic       prevWe [2];
    logic [2:0] mem [2][NPIX];

    always @(negedge aClock) begin
        for (int d = 0; d < 2; d++) begin
            if (weO[d] === 1'b1) begin
                wrCount[d]++;
                if (int'(addrO[d]) != nextAddr[d] || prevWe[d] === 1'b1)
                    orderErr[d]++;
                nextAddr[d] = int'(addrO[d]) + 1;
                if (int'(addrO[d]) > maxAddr[d])
                    maxAddr[d] = int'(addrO[d]);
                if (int'(addrO[d]) < NPIX)
                    mem[d][int'(addrO[d])] = dataO[d];
                else
                    orderErr[d]++;
            end
            if (shortO[d] === 1'b1)
                shortCount[d]++;
            prevWe[d] = weO[d];
        end
    end

    task automatic clearStats();
        for (int d = 0; d < 2; d++) begin
            wrCount[d] = 0;
            orderErr[d] = 0;
            shortCount[d] = 0;
            nextAddr[d] = 0;
            maxAddr[d] = -1;
            for (int i = 0; i < NPIX; i++)
                mem[d][i] = 3'bxxx;
        end
    endtask

    task automatic tick();
        @(posedge aClock);
        #1;
    endtask

    task automatic vsyncPulse(input bit flipAtVsync);
        vs = 1'b1; flip = flipAtVsync; tick();
        flip = 1'b0; tick(); tick();
        vs = 1'b0; tick(); tick();
    endtask

    // Pixel (x,y): R = x*16, G = y*16, B = 0xFF, so data = {x[3], y[3], 1}.
    task automatic sendLine(input int y, input int width);
        for (int x = 0; x < width; x++) begin
            de = 1'b1; r = 8'(x * 16); g = 8'(y * 16); b = 8'hFF;
            tick();
        end
        de = 1'b0; tick();
        hs = 1'b1; tick();
        hs = 1'b0; tick(); tick();
    endtask

    task automatic sendFrame(input int lines, input int width, input bit flipAtVsync);
        vsyncPulse(flipAtVsync);
        for (int y = 0; y < lines; y++)
            sendLine(y, width);
        tick(); tick();
    endtask

    task automatic pulseFlip();
        flip = 1'b1; tick();
        flip = 1'b0; tick();
    endtask

    task automatic test_reset();
        aReset = 1'b0;
        tick(); tick(); tick();
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (weO[d] !== 1'b0 || doneO[d] !== 1'b0 || shortO[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset_ctrl dut%0d: we/done/short=%b%b%b want 000", d, weO[d], doneO[d], shortO[d]);
            end
            tests++;
            if (dropO[d] !== 8'd0 || addrO[d] !== 18'd0 || dataO[d] !== 3'd0) begin
                fails++;
                $display("FAIL reset_data dut%0d: drop=%0d addr=%0d data=%b want 0", d, dropO[d], addrO[d], dataO[d]);
            end
        end
        #2 aReset = 1'b1;
        tick();
    endtask

    task automatic test_capture();
        clearStats();
        sendFrame(H, W, 1'b0);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (wrCount[d] !== 0 || doneO[d] !== 1'b0) begin
                fails++;
                $display("FAIL skip_first dut%0d: writes=%0d done=%b want 0 0", d, wrCount[d], doneO[d]);
            end
        end
        for (int f = 0; f < 2; f++) begin
            clearStats();
            sendFrame(H, W, 1'b0);
            for (int d = 0; d < 2; d++) begin
                tests++;
                if (wrCount[d] !== NPIX || orderErr[d] !== 0 || maxAddr[d] !== NPIX - 1) begin
                    fails++;
                    $display("FAIL capture_count dut%0d f%0d: writes=%0d orderErr=%0d max=%0d want %0d 0 %0d",
                             d, f, wrCount[d], orderErr[d], maxAddr[d], NPIX, NPIX - 1);
                end
                tests++;
                if (mem[d][9] !== 3'b001 || mem[d][37] !== 3'b111 || mem[d][31] !== 3'b101 || mem[d][0] !== 3'b001) begin
                    fails++;
                    $display("FAIL capture_data dut%0d: m9=%b m37=%b m31=%b m0=%b want 001 111 101 001",
                             d, mem[d][9], mem[d][37], mem[d][31], mem[d][0]);
                end
                tests++;
                if (doneO[d] !== 1'b1) begin
                    fails++;
                    $display("FAIL capture_done dut%0d: done=%b want 1", d, doneO[d]);
                end
            end
            pulseFlip();
            for (int d = 0; d < 2; d++) begin
                tests++;
                if (doneO[d] !== 1'b0) begin
                    fails++;
                    $display("FAIL flip_release dut%0d: done=%b want 0", d, doneO[d]);
                end
            end
        end
    endtask

    task automatic test_drop();
        clearStats();
        sendFrame(H, W, 1'b0);
        clearStats();
        for (int i = 0; i < 3; i++)
            sendFrame(2, W, 1'b0);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (wrCount[d] !== 0 || doneO[d] !== 1'b1 || dropO[d] !== 8'd3) begin
                fails++;
                $display("FAIL drop_count dut%0d: writes=%0d done=%b drop=%0d want 0 1 3", d, wrCount[d], doneO[d], dropO[d]);
            end
        end
        pulseFlip();
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (doneO[d] !== 1'b0 || dropO[d] !== 8'd3) begin
                fails++;
                $display("FAIL drop_flip dut%0d: done=%b drop=%0d want 0 3", d, doneO[d], dropO[d]);
            end
        end
    endtask

    task automatic test_short_frame();
        clearStats();
        sendFrame(H / 2, W, 1'b0);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (wrCount[d] !== 24 || doneO[d] !== 1'b0) begin
                fails++;
                $display("FAIL short_partial dut%0d: writes=%0d done=%b want 24 0", d, wrCount[d], doneO[d]);
            end
        end
        clearStats();
        sendFrame(H, W, 1'b0);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (shortCount[d] !== 1 || wrCount[d] !== 0 || doneO[d] !== 1'b0) begin
                fails++;
                $display("FAIL short_pulse dut%0d: pulses=%0d writes=%0d done=%b want 1 0 0",
                         d, shortCount[d], wrCount[d], doneO[d]);
            end
        end
        clearStats();
        sendFrame(H, W, 1'b0);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (wrCount[d] !== NPIX || orderErr[d] !== 0 || doneO[d] !== 1'b1 || shortCount[d] !== 0) begin
                fails++;
                $display("FAIL short_recover dut%0d: writes=%0d orderErr=%0d done=%b pulses=%0d want %0d 0 1 0",
                         d, wrCount[d], orderErr[d], doneO[d], shortCount[d], NPIX);
            end
        end
        pulseFlip();
    endtask

    task automatic test_oversize();
        clearStats();
        sendFrame(H + 2, W + 4, 1'b0);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (wrCount[d] !== NPIX || orderErr[d] !== 0 || maxAddr[d] !== NPIX - 1) begin
                fails++;
                $display("FAIL oversize_count dut%0d: writes=%0d orderErr=%0d max=%0d want %0d 0 %0d",
                         d, wrCount[d], orderErr[d], maxAddr[d], NPIX, NPIX - 1);
            end
            tests++;
            if (mem[d][47] !== 3'b111 || doneO[d] !== 1'b1) begin
                fails++;
                $display("FAIL oversize_tail dut%0d: m47=%b done=%b want 111 1", d, mem[d][47], doneO[d]);
            end
        end
    endtask

    task automatic test_flip_vsync();
        clearStats();
        sendFrame(H, W, 1'b1);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (dropO[d] !== 8'd3 || wrCount[d] !== 0 || doneO[d] !== 1'b0) begin
                fails++;
                $display("FAIL flip_vsync dut%0d: drop=%0d writes=%0d done=%b want 3 0 0", d, dropO[d], wrCount[d], doneO[d]);
            end
        end
        clearStats();
        sendFrame(H, W, 1'b0);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (wrCount[d] !== NPIX || doneO[d] !== 1'b1) begin
                fails++;
                $display("FAIL flip_vsync_next dut%0d: writes=%0d done=%b want %0d 1", d, wrCount[d], doneO[d], NPIX);
            end
        end
    endtask

    task automatic test_reset_mid();
        #2 aReset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (doneO[d] !== 1'b0 || dropO[d] !== 8'd0) begin
                fails++;
                $display("FAIL async_reset_done dut%0d: done=%b drop=%0d want 0 0", d, doneO[d], dropO[d]);
            end
        end
        tick();
        #2 aReset = 1'b1;
        tick();
        clearStats();
        sendFrame(H, W, 1'b0);
        vsyncPulse(1'b0);
        sendLine(0, W);
        sendLine(1, W);
        for (int x = 0; x < 6; x++) begin
            de = 1'b1; r = 8'(x * 16); g = 8'(2 * 16); b = 8'hFF;
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (weO[d] !== 1'b1 || addrO[d] !== 18'd10) begin
                fails++;
                $display("FAIL midline_write dut%0d: we=%b addr=%0d want 1 10", d, weO[d], addrO[d]);
            end
        end
        #2 aReset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (weO[d] !== 1'b0 || doneO[d] !== 1'b0 || addrO[d] !== 18'd0) begin
                fails++;
                $display("FAIL async_reset_we dut%0d: we=%b done=%b addr=%0d want 0 0 0", d, weO[d], doneO[d], addrO[d]);
            end
        end
        de = 1'b0;
        tick();
        #2 aReset = 1'b1;
        tick();
        clearStats();
        sendFrame(H, W, 1'b0);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (wrCount[d] !== 0) begin
                fails++;
                $display("FAIL resync_skip dut%0d: writes=%0d want 0", d, wrCount[d]);
            end
        end
        clearStats();
        sendFrame(H, W, 1'b0);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (wrCount[d] !== NPIX || orderErr[d] !== 0 || doneO[d] !== 1'b1 || mem[d][9] !== 3'b001) begin
                fails++;
                $display("FAIL resync_frame dut%0d: writes=%0d orderErr=%0d done=%b m9=%b want %0d 0 1 001",
                         d, wrCount[d], orderErr[d], doneO[d], mem[d][9], NPIX);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vs = 1'b0; hs = 1'b0; de = 1'b0; flip = 1'b0;
        r = 8'd0; g = 8'd0; b = 8'd0;
        aReset = 1'b0;
        clearStats();
        test_reset();
        test_capture();
        test_drop();
        test_short_frame();
        test_oversize();
        test_flip_vsync();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
